// File: rtl/tile_scene_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tile_scene_renderer                                         |
// | Brief  : Grid level renderer (walls, goals, boxes, player sprite),   |
// |          2-cycle pixel latency, per-frame goal/coverage tally.       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tile_scene_renderer #(
  parameter int TILE    = 20,
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12,
  parameter int ORG_X   = 160,
  parameter int ORG_Y   = 120,
  parameter int NUM_BOX = 4,
  parameter int SA_W    = 9
) (
  input  logic                 pixelclk,
  input  logic                 reset_n,
  input  logic [11:0]          hcount,
  input  logic [11:0]          vcount,
  input  logic                 i_vsync,
  input  logic [4:0]           man_gx,
  input  logic [4:0]           man_gy,
  input  logic [5*NUM_BOX-1:0] box_gx,
  input  logic [5*NUM_BOX-1:0] box_gy,
  output logic [9:0]           map_addr,
  input  logic [1:0]           map_data,
  output logic [SA_W-1:0]      spr_addr,
  input  logic [23:0]          spr_data,
  output logic [23:0]          dout,
  output logic [7:0]           goals_left,
  output logic                 level_done
);

  localparam int                c_sub_w     = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [c_sub_w-1:0] c_tile_last = c_sub_w'(TILE - 1);
  localparam logic [SA_W-1:0]   c_tile_step = SA_W'(TILE);
  localparam logic [11:0]       c_org_x     = 12'(ORG_X);
  localparam logic [11:0]       c_org_y     = 12'(ORG_Y);
  localparam logic [5:0]        c_grid_w    = 6'(GRID_W);
  localparam logic [5:0]        c_grid_h    = 6'(GRID_H);
  localparam logic [1:0]        c_t_wall    = 2'd1;
  localparam logic [1:0]        c_t_goal    = 2'd2;
  localparam logic [23:0]       c_rgb_white = 24'hFFFFFF;
  localparam logic [23:0]       c_rgb_wall  = 24'hFFC125;
  localparam logic [23:0]       c_rgb_boxg  = 24'h00FF00;
  localparam logic [23:0]       c_rgb_box   = 24'hFF0000;
  localparam logic [23:0]       c_rgb_goal  = 24'h0000FF;

  // Sub-tile position of the previous pixel; the current one is derived by stepping it.
  logic [c_sub_w-1:0] r_subx, r_suby;
  logic [5:0]         r_col, r_row;
  logic [SA_W-1:0]    r_soff;
  logic [11:0]        r_vprev;

  logic [c_sub_w-1:0] w_subx, w_suby;
  logic [5:0]         w_col, w_row;
  logic [SA_W-1:0]    w_soff, w_spr;
  logic               w_in_grid, w_samp, w_box_hit, w_man_hit;
  logic [NUM_BOX-1:0] w_box_vec;

  // S0 -> S1 pipeline
  logic [9:0]      r_map_addr;
  logic [SA_W-1:0] r_spr_addr;
  logic            r_vs1, r_in1, r_samp1, r_box1, r_man1;

  // S2 and frame bookkeeping
  logic [23:0] r_dout, w_pix;
  logic [7:0]  r_goal, r_cov, r_goals_left;
  logic        r_level_done, r_vs_prev, r_started;
  logic        w_fall, w_rise, w_goal_tap;

  always_comb begin
    w_subx = r_subx + 1'b1;
    w_col  = r_col;
    if (hcount == c_org_x) begin
      w_subx = '0;
      w_col  = '0;
    end else if (r_subx == c_tile_last) begin
      w_subx = '0;
      if (r_col != c_grid_w) w_col = r_col + 6'd1;
    end
  end

  // Vertical position advances only on the first pixel of a new line.
  always_comb begin
    w_suby = r_suby;
    w_row  = r_row;
    w_soff = r_soff;
    if (vcount == c_org_y) begin
      w_suby = '0;
      w_row  = '0;
      w_soff = '0;
    end else if (vcount != r_vprev) begin
      if (r_suby == c_tile_last) begin
        w_suby = '0;
        w_soff = '0;
        if (r_row != c_grid_h) w_row = r_row + 6'd1;
      end else begin
        w_suby = r_suby + 1'b1;
        w_soff = r_soff + c_tile_step;
      end
    end
  end

  assign w_spr     = w_soff + SA_W'(w_subx);
  assign w_samp    = (w_subx == '0) && (w_suby == '0);
  assign w_in_grid = i_vsync && (hcount >= c_org_x) && (vcount >= c_org_y) &&
                     (w_col < c_grid_w) && (w_row < c_grid_h);

  for (genvar gi = 0; gi < NUM_BOX; gi++) begin : g_box
    assign w_box_vec[gi] = ({1'b0, box_gx[5*gi +: 5]} < c_grid_w) &&
                           ({1'b0, box_gy[5*gi +: 5]} < c_grid_h) &&
                           ({1'b0, box_gx[5*gi +: 5]} == w_col) &&
                           ({1'b0, box_gy[5*gi +: 5]} == w_row);
  end

  assign w_box_hit = |w_box_vec;
  assign w_man_hit = ({1'b0, man_gx} < c_grid_w) && ({1'b0, man_gy} < c_grid_h) &&
                     ({1'b0, man_gx} == w_col) && ({1'b0, man_gy} == w_row);

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_subx     <= '0;
      r_suby     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_soff     <= '0;
      r_vprev    <= '0;
      r_map_addr <= '0;
      r_spr_addr <= '0;
      r_vs1      <= 1'b0;
      r_in1      <= 1'b0;
      r_samp1    <= 1'b0;
      r_box1     <= 1'b0;
      r_man1     <= 1'b0;
    end else begin
      r_vprev <= vcount;
      r_vs1   <= i_vsync;
      r_in1   <= w_in_grid;
      r_samp1 <= w_samp;
      r_box1  <= w_box_hit;
      r_man1  <= w_man_hit;
      if (!i_vsync) begin
        r_subx     <= '0;
        r_suby     <= '0;
        r_col      <= '0;
        r_row      <= '0;
        r_soff     <= '0;
        r_map_addr <= '0;
        r_spr_addr <= '0;
      end else begin
        r_subx     <= w_subx;
        r_suby     <= w_suby;
        r_col      <= w_col;
        r_row      <= w_row;
        r_soff     <= w_soff;
        r_map_addr <= {w_row[4:0], w_col[4:0]};
        r_spr_addr <= w_spr;
      end
    end
  end

  always_comb begin
    w_pix = c_rgb_white;
    if (!r_vs1)                                w_pix = 24'h000000;
    else if (!r_in1)                           w_pix = c_rgb_white;
    else if (map_data == c_t_wall)             w_pix = c_rgb_wall;
    else if (r_box1 && map_data == c_t_goal)   w_pix = c_rgb_boxg;
    else if (r_box1)                           w_pix = c_rgb_box;
    else if (r_man1)                           w_pix = spr_data;
    else if (map_data == c_t_goal)             w_pix = c_rgb_goal;
  end

  assign w_fall     = r_vs_prev & ~i_vsync;
  assign w_rise     = ~r_vs_prev & i_vsync;
  assign w_goal_tap = r_vs1 & r_in1 & r_samp1 & (map_data == c_t_goal);

  // r_vs_prev resets high so a reset in mid-frame is not mistaken for a frame start.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout       <= '0;
      r_goal       <= '0;
      r_cov        <= '0;
      r_goals_left <= '0;
      r_level_done <= 1'b0;
      r_vs_prev    <= 1'b1;
      r_started    <= 1'b0;
    end else begin
      r_dout    <= w_pix;
      r_vs_prev <= i_vsync;
      if (w_rise) r_started <= 1'b1;
      if (w_fall) begin
        if (r_started) begin
          r_goals_left <= r_goal - r_cov;
          r_level_done <= (r_goal != 8'd0) && (r_cov == r_goal);
        end
        r_goal <= '0;
        r_cov  <= '0;
      end else if (w_goal_tap) begin
        if (r_goal != 8'hFF)          r_goal <= r_goal + 8'd1;
        if (r_box1 && r_cov != 8'hFF) r_cov  <= r_cov + 8'd1;
      end
    end
  end

  assign map_addr   = r_map_addr;
  assign spr_addr   = r_spr_addr;
  assign dout       = r_dout;
  assign goals_left = r_goals_left;
  assign level_done = r_level_done;

endmodule
`default_nettype wire

// File: tb/tb_tile_scene_renderer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module : tb_tile_scene_renderer                                      |
// | Brief  : Directed self-checking bench for tile_scene_renderer.       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_tile_scene_renderer;

  localparam int TILE    = 20;
  localparam int GRID_W  = 16;
  localparam int GRID_H  = 12;
  localparam int ORG_X   = 160;
  localparam int ORG_Y   = 120;
  localparam int NUM_BOX = 4;
  localparam int SA_W    = 9;

  logic                 pixelclk = 1'b0;
  logic                 reset_n  = 1'b0;
  logic [11:0]          hcount   = '0;
  logic [11:0]          vcount   = '0;
  logic                 i_vsync  = 1'b0;
  logic [4:0]           man_gx, man_gy;
  logic [5*NUM_BOX-1:0] box_gx, box_gy;
  logic [9:0]           map_addr;
  logic [1:0]           map_data;
  logic [SA_W-1:0]      spr_addr;
  logic [23:0]          spr_data;
  logic [23:0]          dout;
  logic [7:0]           goals_left;
  logic                 level_done;

  logic [1:0] mem [0:1023];
  assign map_data = mem[map_addr];
  assign spr_data = {15'd0, spr_addr};

  always #5 pixelclk = ~pixelclk;

  tile_scene_renderer #(
    .TILE(TILE), .GRID_W(GRID_W), .GRID_H(GRID_H), .ORG_X(ORG_X), .ORG_Y(ORG_Y),
    .NUM_BOX(NUM_BOX), .SA_W(SA_W)
  ) dut (
    .pixelclk  (pixelclk),
    .reset_n   (reset_n),
    .hcount    (hcount),
    .vcount    (vcount),
    .i_vsync   (i_vsync),
    .man_gx    (man_gx),
    .man_gy    (man_gy),
    .box_gx    (box_gx),
    .box_gy    (box_gy),
    .map_addr  (map_addr),
    .map_data  (map_data),
    .spr_addr  (spr_addr),
    .spr_data  (spr_data),
    .dout      (dout),
    .goals_left(goals_left),
    .level_done(level_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic set_box(input int i, input logic [4:0] x, input logic [4:0] y);
    box_gx[5*i +: 5] = x;
    box_gy[5*i +: 5] = y;
  endtask

  // Reference picture straight from pixel coordinates.
  function automatic logic [23:0] model_pix(input int h, input int v);
    int col, row, sx, sy;
    logic [1:0] t;
    logic bh, mh;
    if (h < ORG_X || v < ORG_Y) return 24'hFFFFFF;
    col = (h - ORG_X) / TILE;
    row = (v - ORG_Y) / TILE;
    sx  = (h - ORG_X) % TILE;
    sy  = (v - ORG_Y) % TILE;
    if (col >= GRID_W || row >= GRID_H) return 24'hFFFFFF;
    t  = mem[row*32 + col];
    bh = 1'b0;
    for (int i = 0; i < NUM_BOX; i++)
      if (int'(box_gx[5*i +: 5]) == col && int'(box_gy[5*i +: 5]) == row) bh = 1'b1;
    mh = (int'(man_gx) == col) && (int'(man_gy) == row);
    if (t == 2'd1)         return 24'hFFC125;
    if (bh && t == 2'd2)   return 24'h00FF00;
    if (bh)                return 24'hFF0000;
    if (mh)                return 24'(sy*TILE + sx);
    if (t == 2'd2)         return 24'h0000FF;
    return 24'hFFFFFF;
  endfunction

  int              probe_h [4];
  int              probe_v [4];
  logic [23:0]     cap_dout[4];
  logic [9:0]      cap_map [4];
  logic [SA_W-1:0] cap_spr [4];

  task automatic clear_probes();
    for (int k = 0; k < 4; k++) begin
      probe_h[k]  = -100;
      probe_v[k]  = -100;
      cap_dout[k] = 'x;
      cap_map[k]  = 'x;
      cap_spr[k]  = 'x;
    end
  endtask

  task automatic set_probe(input int k, input int h, input int v);
    probe_h[k] = h;
    probe_v[k] = v;
  endtask

  // Raster a window line by line; dout after each edge belongs to the previous pixel.
  task automatic scan(input string tag, input int v0, input int v1, input int h0, input int h1);
    int nbad = 0;
    int ph = -1;
    int pv = -1;
    for (int v = v0; v <= v1; v++) begin
      for (int h = h0; h <= h1; h++) begin
        hcount = 12'(h);
        vcount = 12'(v);
        tick();
        for (int k = 0; k < 4; k++) begin
          if (h == probe_h[k] && v == probe_v[k]) begin
            cap_map[k] = map_addr;
            cap_spr[k] = spr_addr;
          end
          if (ph == probe_h[k] && pv == probe_v[k]) cap_dout[k] = dout;
        end
        if (ph >= 0 && dout !== model_pix(ph, pv)) nbad++;
        ph = h;
        pv = v;
      end
    end
    hcount = '0;
    tick();
    for (int k = 0; k < 4; k++)
      if (ph == probe_h[k] && pv == probe_v[k]) cap_dout[k] = dout;
    if (dout !== model_pix(ph, pv)) nbad++;
    check_eq({tag, "_pixels_bad"}, nbad, 0);
  endtask

  task automatic frame(input string tag, input int v1, input int h1);
    if (i_vsync == 1'b0) begin
      hcount  = '0;
      vcount  = '0;
      i_vsync = 1'b1;
      repeat (2) tick();
    end
    scan(tag, ORG_Y, v1, ORG_X - 2, h1);
    hcount = '0;
    repeat (2) tick();
    i_vsync = 1'b0;
    repeat (2) tick();
    check_eq({tag, "_blank_dout"}, dout, 24'h000000);
    check_eq({tag, "_blank_map_addr"}, map_addr, 10'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 2'd0;
    man_gx = 5'd31;
    man_gy = 5'd31;
    for (int i = 0; i < NUM_BOX; i++) set_box(i, 5'd31, 5'd31);
    clear_probes();

    repeat (3) tick();
    check_eq("reset_dout", dout, 24'h000000);
    check_eq("reset_map_addr", map_addr, 10'd0);
    check_eq("reset_spr_addr", spr_addr, 9'd0);
    check_eq("reset_goals_left", goals_left, 8'd0);
    check_eq("reset_level_done", level_done, 1'b0);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of a line while drawing, with a goal waiting at (1,1)
    mem[1*32 + 1] = 2'd2;
    i_vsync = 1'b1;
    vcount  = 12'(ORG_Y + 5);
    for (int h = ORG_X; h <= ORG_X + 10; h++) begin
      hcount = 12'(h);
      tick();
    end
    #2 reset_n = 1'b0;
    #1;
    check_eq("midreset_dout", dout, 24'h000000);
    check_eq("midreset_level_done", level_done, 1'b0);
    @(negedge pixelclk);
    reset_n = 1'b1;
    hcount  = 12'(ORG_X + 11);
    tick();
    check_eq("midreset_lag1_dout", dout, 24'h000000);
    hcount = 12'(ORG_X + 12);
    tick();
    check_eq("midreset_first_pixel", dout, 24'hFFFFFF);

    clear_probes();
    set_probe(0, ORG_X + 20, ORG_Y + 20);
    frame("partial", ORG_Y + 20, ORG_X + 40);
    check_eq("partial_goal_dout", cap_dout[0], 24'h0000FF);
    check_eq("partial_no_commit_goals_left", goals_left, 8'd0);
    check_eq("partial_no_commit_level_done", level_done, 1'b0);
    mem[1*32 + 1] = 2'd0;

    // Single wall at (3,2)
    mem[2*32 + 3] = 2'd1;
    clear_probes();
    set_probe(0, ORG_X + 60, ORG_Y + 40);
    set_probe(1, ORG_X + 79, ORG_Y + 59);
    set_probe(2, ORG_X + 80, ORG_Y + 59);
    set_probe(3, ORG_X + 59, ORG_Y + 40);
    frame("wall", ORG_Y + 59, ORG_X + 99);
    check_eq("wall_topleft_dout", cap_dout[0], 24'hFFC125);
    check_eq("wall_topleft_map_addr", cap_map[0], 10'd67);
    check_eq("wall_botright_dout", cap_dout[1], 24'hFFC125);
    check_eq("wall_right_edge_floor", cap_dout[2], 24'hFFFFFF);
    check_eq("wall_left_edge_floor", cap_dout[3], 24'hFFFFFF);
    check_eq("wall_goals_left", goals_left, 8'd0);
    check_eq("wall_level_done", level_done, 1'b0);
    mem[2*32 + 3] = 2'd0;

    // Goals at (4,4) and (1,3); player under a box at (2,2)
    mem[4*32 + 4] = 2'd2;
    mem[3*32 + 1] = 2'd2;
    set_box(0, 5'd4, 5'd4);
    set_box(1, 5'd0, 5'd0);
    set_box(2, 5'd2, 5'd2);
    set_box(3, 5'd31, 5'd31);
    man_gx = 5'd2;
    man_gy = 5'd2;
    clear_probes();
    set_probe(0, ORG_X + 85, ORG_Y + 85);
    set_probe(1, ORG_X + 25, ORG_Y + 65);
    set_probe(2, ORG_X + 45, ORG_Y + 45);
    set_probe(3, ORG_X + 5,  ORG_Y + 5);
    frame("goalsA", ORG_Y + 85, ORG_X + 99);
    check_eq("goalsA_box_on_goal", cap_dout[0], 24'h00FF00);
    check_eq("goalsA_open_goal", cap_dout[1], 24'h0000FF);
    check_eq("goalsA_box_over_player", cap_dout[2], 24'hFF0000);
    check_eq("goalsA_box_floor", cap_dout[3], 24'hFF0000);
    check_eq("goalsA_goals_left", goals_left, 8'd1);
    check_eq("goalsA_level_done", level_done, 1'b0);

    set_box(1, 5'd1, 5'd3);
    clear_probes();
    set_probe(1, ORG_X + 25, ORG_Y + 65);
    frame("goalsB", ORG_Y + 85, ORG_X + 99);
    check_eq("goalsB_second_goal_covered", cap_dout[1], 24'h00FF00);
    check_eq("goalsB_goals_left", goals_left, 8'd0);
    check_eq("goalsB_level_done", level_done, 1'b1);
    mem[4*32 + 4] = 2'd0;
    mem[3*32 + 1] = 2'd0;

    // Player sprite at (1,1), boxes on plain floor, no goals in the map
    man_gx = 5'd1;
    man_gy = 5'd1;
    set_box(0, 5'd0, 5'd0);
    set_box(1, 5'd2, 5'd1);
    set_box(2, 5'd31, 5'd31);
    set_box(3, 5'd31, 5'd31);
    clear_probes();
    set_probe(0, ORG_X + 20, ORG_Y + 20);
    set_probe(1, ORG_X + 39, ORG_Y + 20);
    set_probe(2, ORG_X + 25, ORG_Y + 27);
    set_probe(3, ORG_X + 45, ORG_Y + 25);
    frame("player", ORG_Y + 39, ORG_X + 59);
    check_eq("player_spr_addr_first", cap_spr[0], 9'd0);
    check_eq("player_spr_addr_row_end", cap_spr[1], 9'd19);
    check_eq("player_spr_addr_5_7", cap_spr[2], 9'd145);
    check_eq("player_dout_5_7", cap_dout[2], 24'h000091);
    check_eq("player_box_dout", cap_dout[3], 24'hFF0000);
    check_eq("nogoal_goals_left", goals_left, 8'd0);
    check_eq("nogoal_level_done", level_done, 1'b0);

    // Two boxes stacked on one goal, others off-grid
    mem[2*32 + 2] = 2'd2;
    set_box(0, 5'd2, 5'd2);
    set_box(1, 5'd2, 5'd2);
    set_box(2, 5'd31, 5'd2);
    set_box(3, 5'd17, 5'd1);
    man_gx = 5'd31;
    man_gy = 5'd31;
    clear_probes();
    set_probe(0, ORG_X + 45, ORG_Y + 45);
    set_probe(1, ORG_X + 25, ORG_Y + 25);
    set_probe(2, ORG_X + 75, ORG_Y + 45);
    frame("dup", ORG_Y + 59, ORG_X + 79);
    check_eq("dup_green_once", cap_dout[0], 24'h00FF00);
    check_eq("dup_offgrid_not_drawn", cap_dout[1], 24'hFFFFFF);
    check_eq("dup_floor_right", cap_dout[2], 24'hFFFFFF);
    check_eq("dup_goals_left", goals_left, 8'd0);
    check_eq("dup_level_done", level_done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
